// File: rtl/mnist_fp16_pkg.sv
// rtl/mnist_fp16_pkg.sv - shared FP16 types, constants and ordering helpers for the MNIST datapath
package mnist_fp16_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t      FP16_POS_ZERO = 16'h0000;
    localparam fp16_t      FP16_NEG_ZERO = 16'h8000;
    localparam logic [4:0] FP16_EXP_MAX  = 5'h1F;
    localparam logic [15:0] FP16_ZERO_KEY = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_t;

    function automatic logic fp16_is_nan(input fp16_t x);
        return (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'd0);
    endfunction

    // Unsigned key whose ordering matches the score ordering: NaN sorts lowest,
    // both zeros share one key, negatives sit below the zero key.
    function automatic logic [15:0] fp16_key(input fp16_t x);
        if (fp16_is_nan(x))
            return 16'h0000;
        else if (x[14:0] == 15'd0)
            return FP16_ZERO_KEY;
        else if (!x[15])
            return x ^ 16'h8000;
        else
            return ~x;
    endfunction

    function automatic fp16_t fp16_norm(input fp16_t x);
        if (fp16_is_nan(x) || (x == FP16_NEG_ZERO))
            return FP16_POS_ZERO;
        else
            return x;
    endfunction

endpackage

// File: rtl/fp16_cmp_gt.sv
// rtl/fp16_cmp_gt.sv - combinational FP16 strict greater-than on the total-order key
module fp16_cmp_gt
    import mnist_fp16_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output logic  a_gt_b
);

    assign a_gt_b = fp16_key(a) > fp16_key(b);

endmodule

// File: rtl/argmax_fp16_seq.sv
// rtl/argmax_fp16_seq.sv - sequential argmax over snapshotted FP16 class scores
module argmax_fp16_seq
    import mnist_fp16_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N_CLASSES = 10,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     scores [N_CLASSES-1:0],
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDX_WIDTH-1:0] digit,
    output logic [WIDTH-1:0]     max_score,
    output logic                 all_zero
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_CLASSES - 1);

    argmax_state_t        state_q, state_d;
    logic [WIDTH-1:0]     snap_q [N_CLASSES-1:0];
    fp16_t                best_q;
    logic [IDX_WIDTH-1:0] best_idx_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic                 cand_gt;

    fp16_cmp_gt u_cmp (
        .a      (snap_q[idx_q]),
        .b      (best_q),
        .a_gt_b (cand_gt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)                  state_d = SCAN;
            SCAN: if (idx_q == LAST_IDX)      state_d = DONE;
            DONE: if (res_valid && res_ready) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshot and scan datapath; the live scores[] are only looked at in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= '0;
            best_q     <= FP16_POS_ZERO;
            best_idx_q <= '0;
            idx_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= scores[i];
                        best_q     <= scores[0];
                        best_idx_q <= '0;
                        idx_q      <= IDX_WIDTH'(1);
                    end
                end
                SCAN: begin
                    if (cand_gt) begin
                        best_q     <= snap_q[idx_q];
                        best_idx_q <= idx_q;
                    end
                    if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers load on the first DONE cycle and then hold until the handoff.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            digit     <= '0;
            max_score <= '0;
            all_zero  <= 1'b0;
        end else if (state_q == DONE) begin
            if (!res_valid) begin
                res_valid <= 1'b1;
                digit     <= best_idx_q;
                max_score <= fp16_norm(best_q);
                all_zero  <= (fp16_key(best_q) == FP16_ZERO_KEY);
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_argmax_fp16_seq.sv
// tb/tb_argmax_fp16_seq.sv - directed table-driven bench for argmax_fp16_seq
module tb_argmax_fp16_seq;

    localparam int N = 10;

    typedef struct packed {
        logic [N-1:0][15:0] sc;
        logic [3:0]         d;
        logic [15:0]        m;
        logic               z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        res_ready = 1'b1;
    logic [15:0] scores [N-1:0];
    logic        busy;
    logic        res_valid;
    logic [3:0]  digit;
    logic [15:0] max_score;
    logic        all_zero;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs [7];

    argmax_fp16_seq #(.WIDTH(16), .N_CLASSES(N), .IDX_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .scores    (scores),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .digit     (digit),
        .max_score (max_score),
        .all_zero  (all_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < N; i++) scores[i] = v.sc[i];
    endtask

    task automatic start_and_wait(input vec_t v, input string tag);
        int lat;
        load(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_digit"}, digit, v.d);
        chk({tag, "_max"}, max_score, v.m);
        chk({tag, "_zero"}, all_zero, v.z);
    endtask

    task automatic handoff(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_clr"}, res_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            vecs[0].sc[i] = 16'h3C00;
            vecs[1].sc[i] = 16'h0000;
            vecs[2].sc[i] = (i % 2) ? 16'h8000 : 16'h0000;
            vecs[3].sc[i] = 16'hC200;
            vecs[4].sc[i] = 16'h7BFF;
            vecs[5].sc[i] = 16'h8000;
            vecs[6].sc[i] = 16'hBC00;
        end
        vecs[0].sc[7] = 16'h4500; vecs[0].d = 4'd7; vecs[0].m = 16'h4500; vecs[0].z = 1'b0;
        vecs[1].sc[2] = 16'h4200; vecs[1].sc[8] = 16'h4200;
        vecs[1].d = 4'd2; vecs[1].m = 16'h4200; vecs[1].z = 1'b0;
        vecs[2].sc[0] = 16'h8000; vecs[2].sc[4] = 16'h7E00;
        vecs[2].d = 4'd0; vecs[2].m = 16'h0000; vecs[2].z = 1'b1;
        vecs[3].sc[0] = 16'hC000; vecs[3].sc[1] = 16'hBC00; vecs[3].sc[2] = 16'hC400;
        vecs[3].d = 4'd1; vecs[3].m = 16'hBC00; vecs[3].z = 1'b0;
        vecs[4].sc[9] = 16'h7C00; vecs[4].sc[5] = 16'hFE00;
        vecs[4].d = 4'd9; vecs[4].m = 16'h7C00; vecs[4].z = 1'b0;
        vecs[5].sc[0] = 16'h7E01; vecs[5].sc[1] = 16'hFC00; vecs[5].sc[3] = 16'h0001;
        vecs[5].d = 4'd3; vecs[5].m = 16'h0001; vecs[5].z = 1'b0;
        vecs[6].sc[0] = 16'h7C01; vecs[6].sc[1] = 16'h8000;
        vecs[6].d = 4'd1; vecs[6].m = 16'h0000; vecs[6].z = 1'b1;

        for (int i = 0; i < N; i++) scores[i] = 16'h0000;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_digit", digit, 0);
        chk("rst_max", max_score, 0);
        chk("rst_zero", all_zero, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            start_and_wait(vecs[v], $sformatf("vec%0d", v));
            handoff($sformatf("vec%0d", v));
        end

        // Backpressure with start pulses while holding, and start during the handoff edge.
        res_ready = 1'b0;
        start_and_wait(vecs[3], "bp");
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            @(posedge clk); #1;
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_busy", busy, 1);
            chk("bp_hold_digit", digit, 4'd1);
            chk("bp_hold_max", max_score, 16'hBC00);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("bp_handoff_valid", res_valid, 0);
        chk("bp_handoff_idle", busy, 0);
        @(posedge clk); #1;
        chk("bp_start_ignored", busy, 0);

        // Scores change mid-scan; result must reflect the snapshot.
        begin
            int lat;
            load(vecs[0]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            scores[3] = 16'h7000;
            scores[7] = 16'h0000;
            lat = 2;
            while (!res_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("snap_latency", lat, 10);
            chk("snap_digit", digit, 4'd7);
            chk("snap_max", max_score, 16'h4500);
            handoff("snap");
        end

        // Asynchronous reset in the middle of a scan.
        load(vecs[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", res_valid, 0);
        chk("arst_digit", digit, 0);
        chk("arst_max", max_score, 0);
        chk("arst_zero", all_zero, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        start_and_wait(vecs[1], "post_rst");
        handoff("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
